// File: rtl/vga_sync_gen.sv
// vga_sync_gen: parametrised VGA timing generator with pixel-rate prescaler,
// programmable sync polarity and registered colour gating.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int COLOR_W  = 1,
  parameter int CNT_W    = 10,
  parameter int CLK_DIV  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [COLOR_W-1:0] red_in,
  input  logic [COLOR_W-1:0] green_in,
  input  logic [COLOR_W-1:0] blue_in,
  output logic [COLOR_W-1:0] red_out,
  output logic [COLOR_W-1:0] green_out,
  output logic [COLOR_W-1:0] blue_out,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [CNT_W-1:0]   hor_count,
  output logic [CNT_W-1:0]   ver_count,
  output logic               pixel_tick,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PS_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(CLK_DIV - 1);
  localparam logic             HS_ON    = (HS_POL != 0);
  localparam logic             VS_ON    = (VS_POL != 0);

  logic [PS_W-1:0]    ps_q, ps_d;
  logic [CNT_W-1:0]   hor_q, hor_d;
  logic [CNT_W-1:0]   ver_q, ver_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               video_on_q, video_on_d;
  logic               frame_start_q, frame_start_d;
  logic [COLOR_W-1:0] red_q, red_d;
  logic [COLOR_W-1:0] green_q, green_d;
  logic [COLOR_W-1:0] blue_q, blue_d;
  logic               tick;
  logic               active;

  // Prescaler and raster counters: advance on the pixel tick, wrap at line/frame end.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    ps_d  = ps_q;
    hor_d = hor_q;
    ver_d = ver_q;
    tick  = enable && (ps_q == PS_LAST);
    if (enable) begin
      // >= rather than == keeps the counters bounded even from an odd state.
      ps_d = (ps_q >= PS_LAST) ? '0 : ps_q + PS_W'(1);
    end
    if (tick) begin
      if (hor_q >= H_LAST) begin
        hor_d = '0;
        ver_d = (ver_q >= V_LAST) ? '0 : ver_q + CNT_W'(1);
      end else begin
        hor_d = hor_q + CNT_W'(1);
      end
    end
  end

  // Output decode from the current counters; registered next edge (one clk behind).
  always_comb begin
    active        = (hor_q < H_ACT) && (ver_q < V_ACT);
    video_on_d    = enable && active;
    hsync_d       = (enable && hor_q >= HS_START && hor_q < HS_END) ? HS_ON : ~HS_ON;
    vsync_d       = (enable && ver_q >= VS_START && ver_q < VS_END) ? VS_ON : ~VS_ON;
    red_d         = video_on_d ? red_in   : '0;
    green_d       = video_on_d ? green_in : '0;
    blue_d        = video_on_d ? blue_in  : '0;
    frame_start_d = tick && (hor_q >= H_LAST) && (ver_q >= V_LAST);
  end

  // State registers with synchronous reset taking priority over enable.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      ps_q          <= '0;
      hor_q         <= '0;
      ver_q         <= '0;
      hsync_q       <= ~HS_ON;
      vsync_q       <= ~VS_ON;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
    end else begin
      ps_q          <= ps_d;
      hor_q         <= hor_d;
      ver_q         <= ver_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
    end
  end

  assign hor_count   = hor_q;
  assign ver_count   = ver_q;
  assign pixel_tick  = tick;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;
  assign red_out     = red_q;
  assign green_out   = green_q;
  assign blue_out    = blue_q;

endmodule
